// File: rtl/axil_fw_err_regs_if.sv
// axil_fw_err_regs_if: AXI-Lite control bus between the control master and the error-register block
interface axil_fw_err_regs_if #(
    parameter int G_DATA_W      = 32,
    parameter int G_CTRL_ADDR_W = 5
);
    logic                     awvalid;
    logic                     awready;
    logic [G_CTRL_ADDR_W-1:0] awaddr;
    logic [2:0]               awprot;
    logic                     wvalid;
    logic                     wready;
    logic [G_DATA_W-1:0]      wdata;
    logic [G_DATA_W/8-1:0]    wstrb;
    logic                     bvalid;
    logic                     bready;
    logic [1:0]               bresp;
    logic                     arvalid;
    logic                     arready;
    logic [G_CTRL_ADDR_W-1:0] araddr;
    logic [2:0]               arprot;
    logic                     rvalid;
    logic                     rready;
    logic [G_DATA_W-1:0]      rdata;
    logic [1:0]               rresp;

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_fw_err_regs.sv
// axil_fw_err_regs: AXI-Lite responder holding seven saturating error counters and an IRQ mask
module axil_fw_err_regs #(
    parameter int G_CNT_WDT     = 4,
    parameter int G_DATA_W      = 32,
    parameter int G_CTRL_ADDR_W = 5,
    parameter logic [G_CTRL_ADDR_W-1:0] G_WR_SLVERR_ADDR = 'h00,
    parameter logic [G_CTRL_ADDR_W-1:0] G_WR_DECERR_ADDR = 'h04,
    parameter logic [G_CTRL_ADDR_W-1:0] G_WR_WD_ERR_ADDR = 'h08,
    parameter logic [G_CTRL_ADDR_W-1:0] G_RD_SLVERR_ADDR = 'h0c,
    parameter logic [G_CTRL_ADDR_W-1:0] G_RD_DECERR_ADDR = 'h10,
    parameter logic [G_CTRL_ADDR_W-1:0] G_RD_WD_ERR_ADDR = 'h14,
    parameter logic [G_CTRL_ADDR_W-1:0] G_RG_ST_ERR_ADDR = 'h18,
    parameter logic [G_CTRL_ADDR_W-1:0] G_IRQ_MASK_ADDR  = 'h1c
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [6:0]         i_err_evt,
    output logic               o_irq,
    axil_fw_err_regs_if.slave  ctrl_axil
);
    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;

    // Entries 0..6 are the counters in event-bit order, entry 7 is the mask.
    localparam logic [7:0][G_CTRL_ADDR_W-1:0] addr_map = {
        G_IRQ_MASK_ADDR, G_RG_ST_ERR_ADDR, G_RD_WD_ERR_ADDR, G_RD_DECERR_ADDR,
        G_RD_SLVERR_ADDR, G_WR_WD_ERR_ADDR, G_WR_DECERR_ADDR, G_WR_SLVERR_ADDR
    };

    wstate_t                      wstate;
    rstate_t                      rstate;
    logic                         aw_hs, w_hs, ar_hs, commit;
    logic [G_CTRL_ADDR_W-1:0]     aw_addr, wa;
    logic [G_DATA_W-1:0]          w_data, wd, rd_val;
    logic [G_DATA_W/8-1:0]        w_strb, ws;
    logic [7:0]                   wr_hit, rd_hit;
    logic [6:0][G_CNT_WDT-1:0]    cnt;
    logic [6:0]                   mask, clr, nz;
    logic                         unused_bits;

    assign unused_bits = ^{ctrl_axil.awprot, ctrl_axil.arprot, wd[G_DATA_W-1:7], ws[G_DATA_W/8-1:1]};

    // A handshake in the current cycle bypasses its holding register so the commit happens at once.
    always_comb begin
        aw_hs  = ctrl_axil.awvalid & ctrl_axil.awready;
        w_hs   = ctrl_axil.wvalid & ctrl_axil.wready;
        ar_hs  = ctrl_axil.arvalid & ctrl_axil.arready;
        wa     = aw_hs ? ctrl_axil.awaddr : aw_addr;
        wd     = w_hs ? ctrl_axil.wdata : w_data;
        ws     = w_hs ? ctrl_axil.wstrb : w_strb;
        commit = (aw_hs | wstate == W_HAVE_AW) & (w_hs | wstate == W_HAVE_W);
        rd_val = '0;
        for (int i = 0; i < 8; i++) begin
            wr_hit[i] = wa == addr_map[i] && wa[1:0] == 2'b00;
            rd_hit[i] = ctrl_axil.araddr == addr_map[i] && ctrl_axil.araddr[1:0] == 2'b00;
        end
        for (int i = 0; i < 7; i++) begin
            clr[i] = commit & wr_hit[i] & ws[0];
            nz[i]  = |cnt[i];
            rd_val = rd_hit[i] ? G_DATA_W'(cnt[i]) : rd_val;
        end
        rd_val = rd_hit[7] ? G_DATA_W'(mask) : rd_val;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wstate            <= W_IDLE;
            ctrl_axil.awready <= 1'b1;
            ctrl_axil.wready  <= 1'b1;
            ctrl_axil.bvalid  <= 1'b0;
            ctrl_axil.bresp   <= 2'b00;
            aw_addr           <= '0;
            w_data            <= '0;
            w_strb            <= '0;
        end else begin
            if (aw_hs) aw_addr <= ctrl_axil.awaddr;
            if (w_hs) begin
                w_data <= ctrl_axil.wdata;
                w_strb <= ctrl_axil.wstrb;
            end
            case (wstate)
                W_RESP: if (ctrl_axil.bready) begin
                    wstate            <= W_IDLE;
                    ctrl_axil.bvalid  <= 1'b0;
                    ctrl_axil.awready <= 1'b1;
                    ctrl_axil.wready  <= 1'b1;
                end
                default: if (commit) begin
                    wstate            <= W_RESP;
                    ctrl_axil.bvalid  <= 1'b1;
                    ctrl_axil.bresp   <= |wr_hit ? 2'b00 : 2'b11;
                    ctrl_axil.awready <= 1'b0;
                    ctrl_axil.wready  <= 1'b0;
                end else if (aw_hs) begin
                    wstate            <= W_HAVE_AW;
                    ctrl_axil.awready <= 1'b0;
                end else if (w_hs) begin
                    wstate            <= W_HAVE_W;
                    ctrl_axil.wready  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rstate            <= R_IDLE;
            ctrl_axil.arready <= 1'b1;
            ctrl_axil.rvalid  <= 1'b0;
            ctrl_axil.rdata   <= '0;
            ctrl_axil.rresp   <= 2'b00;
        end else begin
            case (rstate)
                R_RESP: if (ctrl_axil.rready) begin
                    rstate            <= R_IDLE;
                    ctrl_axil.rvalid  <= 1'b0;
                    ctrl_axil.arready <= 1'b1;
                end
                default: if (ar_hs) begin
                    rstate            <= R_RESP;
                    ctrl_axil.rvalid  <= 1'b1;
                    ctrl_axil.arready <= 1'b0;
                    ctrl_axil.rdata   <= rd_val;
                    ctrl_axil.rresp   <= |rd_hit ? 2'b00 : 2'b11;
                end
            endcase
        end
    end

    // A clear coinciding with an event leaves 1 so the event is not lost.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt   <= '0;
            mask  <= 7'h7F;
            o_irq <= 1'b0;
        end else begin
            for (int i = 0; i < 7; i++)
                cnt[i] <= clr[i] ? G_CNT_WDT'(i_err_evt[i]) :
                          (i_err_evt[i] && !(&cnt[i])) ? cnt[i] + 1'b1 : cnt[i];
            if (commit & wr_hit[7] & ws[0]) mask <= wd[6:0];
            o_irq <= |(nz & mask);
        end
    end
endmodule

// File: tb/tb_axil_fw_err_regs.sv
// tb_axil_fw_err_regs: table-driven directed checks of the AXI-Lite error-register block
module tb_axil_fw_err_regs;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] evt = '0;
    logic       irq;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        int          op;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [6:0]  evt;
        int          n;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic        exp_irq;
    } vec_t;
    vec_t tbl[$];

    axil_fw_err_regs_if #(.G_DATA_W(32), .G_CTRL_ADDR_W(5)) bus ();

    axil_fw_err_regs dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_err_evt(evt),
        .o_irq    (irq),
        .ctrl_axil(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input int op, input int addr, input int wdata, input int strb,
                                input int e, input int n, input int exp_data, input int exp_resp,
                                input int exp_irq);
        vec_t v;
        v.op = op; v.addr = addr[4:0]; v.wdata = wdata; v.strb = strb[3:0]; v.evt = e[6:0];
        v.n = n; v.exp_data = exp_data; v.exp_resp = exp_resp[1:0]; v.exp_irq = exp_irq[0];
        tbl.push_back(v);
    endfunction

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        bus.araddr = a;
        bus.arvalid = 1'b1;
        while (!bus.arready && n < 20) begin tick(); n++; end
        check("rd_ready", n < 20, 1);
        tick();
        bus.arvalid = 1'b0;
        check("rd_lat", bus.rvalid, 1);
        d = bus.rdata;
        r = bus.rresp;
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check("rd_done", bus.rvalid, 0);
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
        int n = 0;
        bus.awaddr = a;
        bus.wdata = d;
        bus.wstrb = s;
        bus.awvalid = 1'b1;
        bus.wvalid = 1'b1;
        while (!(bus.awready && bus.wready) && n < 20) begin tick(); n++; end
        check("wr_ready", n < 20, 1);
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b0;
        check("wr_lat", bus.bvalid, 1);
        r = bus.bresp;
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("wr_done", bus.bvalid, 0);
    endtask

    task automatic w_before_aw(input logic [6:0] e);
        bus.wdata = 32'h0;
        bus.wstrb = 4'hF;
        bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("wfirst_awready", bus.awready, 1);
            check("wfirst_wready", bus.wready, 0);
            check("wfirst_bvalid", bus.bvalid, 0);
            if (i == 0) tick();
        end
        bus.awaddr = 5'h08;
        bus.awvalid = 1'b1;
        evt = e;
        tick();
        bus.awvalid = 1'b0;
        evt = '0;
        check("wfirst_bvalid_up", bus.bvalid, 1);
        check("wfirst_bresp", bus.bresp, 0);
        check("wfirst_awready_resp", bus.awready, 0);
        check("wfirst_wready_resp", bus.wready, 0);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("wfirst_bvalid_down", bus.bvalid, 0);
        check("wfirst_awready_back", bus.awready, 1);
        check("wfirst_wready_back", bus.wready, 1);
        check("wfirst_irq", irq, e != 0);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        bus.awvalid = 0; bus.awaddr = 0; bus.awprot = 0; bus.wvalid = 0; bus.wdata = 0;
        bus.wstrb = 0; bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.arprot = 0;
        bus.rready = 0;

        for (int a = 0; a < 32; a += 4) add(0, a, 0, 0, 0, 0, a == 28 ? 32'h7F : 0, 0, 0);
        add(2, 0, 0, 0, 7'h04, 1, 0, 0, 0);
        add(2, 0, 0, 0, 7'h04, 1, 0, 0, 1);
        add(2, 0, 0, 0, 7'h04, 1, 0, 0, 1);
        add(0, 'h08, 0, 0, 0, 0, 3, 0, 1);
        add(2, 0, 0, 0, 7'h01, 20, 0, 0, 1);
        add(0, 'h00, 0, 0, 0, 0, 15, 0, 1);
        add(2, 0, 0, 0, 7'h08, 2, 0, 0, 1);
        add(1, 'h1c, 'h00, 'hF, 0, 0, 0, 0, 0);
        add(1, 'h1c, 'h08, 'hF, 0, 0, 0, 0, 1);
        add(0, 'h1c, 0, 0, 0, 0, 'h08, 0, 1);
        add(1, 'h1c, 'h10, 'hF, 0, 0, 0, 0, 0);
        add(1, 'h1c, 'h7F, 'hF, 0, 0, 0, 0, 1);
        add(1, 'h0c, 32'hFFFF_FFFF, 'h0, 0, 0, 0, 0, 1);
        add(0, 'h0c, 0, 0, 0, 0, 2, 0, 1);
        add(1, 'h0c, 32'hFFFF_FFFF, 'h1, 0, 0, 0, 0, 1);
        add(0, 'h0c, 0, 0, 0, 0, 0, 0, 1);
        add(1, 'h02, 0, 'hF, 0, 0, 0, 3, 1);
        add(0, 'h00, 0, 0, 0, 0, 15, 0, 1);
        add(0, 'h1e, 0, 0, 0, 0, 0, 3, 1);
        add(1, 'h1f, 0, 'hF, 0, 0, 0, 3, 1);
        add(0, 'h1c, 0, 0, 0, 0, 'h7F, 0, 1);
        add(1, 'h1c, 'h04, 'hF, 0, 0, 0, 0, 1);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_awready", bus.awready, 1);
        check("rst_wready", bus.wready, 1);
        check("rst_arready", bus.arready, 1);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_irq", irq, 0);

        foreach (tbl[k]) begin
            case (tbl[k].op)
                0: begin
                    axi_read(tbl[k].addr, d, r);
                    check($sformatf("rdata[%0d]", k), d, tbl[k].exp_data);
                    check($sformatf("rresp[%0d]", k), r, tbl[k].exp_resp);
                end
                1: begin
                    axi_write(tbl[k].addr, tbl[k].wdata, tbl[k].strb, r);
                    check($sformatf("bresp[%0d]", k), r, tbl[k].exp_resp);
                end
                default: begin
                    for (int i = 0; i < tbl[k].n; i++) begin evt = tbl[k].evt; tick(); end
                    evt = '0;
                end
            endcase
            check($sformatf("irq[%0d]", k), irq, tbl[k].exp_irq);
        end

        w_before_aw(7'h00);
        axi_read(5'h08, d, r);
        check("clr_cnt2", d, 0);
        evt = 7'h04;
        repeat (2) tick();
        evt = '0;
        w_before_aw(7'h04);
        axi_read(5'h08, d, r);
        check("clr_evt_cnt2", d, 1);
        axi_write(5'h1c, 32'h7F, 4'hF, r);

        bus.awaddr = 5'h02; bus.wdata = 0; bus.wstrb = 4'hF; bus.araddr = 5'h00;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_bvalid", bus.bvalid, 1);
            check("hold_bresp", bus.bresp, 3);
            check("hold_rvalid", bus.rvalid, 1);
            check("hold_rdata", bus.rdata, 15);
            check("hold_rresp", bus.rresp, 0);
            check("hold_awready", bus.awready, 0);
            check("hold_wready", bus.wready, 0);
            check("hold_arready", bus.arready, 0);
            tick();
        end
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0; bus.rready = 1'b0;
        check("hold_bvalid_down", bus.bvalid, 0);
        check("hold_rvalid_down", bus.rvalid, 0);

        bus.awaddr = 5'h00; bus.wstrb = 4'h1; bus.araddr = 5'h00;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        check("rdclr_rdata", bus.rdata, 15);
        check("rdclr_bresp", bus.bresp, 0);
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0; bus.rready = 1'b0;
        axi_read(5'h00, d, r);
        check("rdclr_after", d, 0);

        evt = 7'h20;
        tick();
        evt = '0;
        bus.awaddr = 5'h1c; bus.wdata = 0; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("mid_bvalid", bus.bvalid, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_bvalid", bus.bvalid, 0);
        check("mid_rst_awready", bus.awready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        axi_read(5'h14, d, r);
        check("mid_cnt5", d, 0);
        axi_read(5'h1c, d, r);
        check("mid_mask", d, 32'h7F);
        check("mid_irq", irq, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
